// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the pipeline sequencing controller and PC mux
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    DRAIN = 2'b01,
    ENTER = 2'b10
  } ctrl_state_t;

  localparam logic [1:0] PC_NEXT   = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_MTVEC  = 2'b10;
  localparam logic [1:0] PC_HOLD   = 2'b11;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stage enables, flushes, valid tracking and interrupt drain/entry
module pipeline_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_haz,
  input  logic             control_haz,
  input  logic             mem_wait,
  input  logic             intr,
  input  logic             intr_en,
  output logic             pc_wr,
  output logic             if_de_en,
  output logic             de_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             de_flush,
  output logic             ex_flush,
  output logic             de_valid,
  output logic             ex_valid,
  output logic             mem_valid,
  output logic             wb_valid,
  output logic             intr_taken,
  output logic             draining,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  ctrl_state_t state_q, state_d;
  logic        de_valid_q, ex_valid_q, mem_valid_q, wb_valid_q;
  logic        de_valid_d, ex_valid_d, mem_valid_d, wb_valid_d;
  logic [1:0]  pc_src;
  logic        lu_bubble, ch_flush;

  always_comb begin
    pc_src     = PC_NEXT;
    if_de_en   = 1'b1;
    de_ex_en   = 1'b1;
    ex_mem_en  = 1'b1;
    mem_wb_en  = 1'b1;
    de_flush   = 1'b0;
    ex_flush   = 1'b0;
    intr_taken = 1'b0;
    draining   = 1'b0;
    lu_bubble  = 1'b0;
    ch_flush   = 1'b0;
    state_d    = state_q;

    case (state_q)
      RUN, DRAIN: begin
        draining = (state_q == DRAIN);
        if (mem_wait) begin
          pc_src    = PC_HOLD;
          if_de_en  = 1'b0;
          de_ex_en  = 1'b0;
          ex_mem_en = 1'b0;
          mem_wb_en = 1'b0;
        end else if (control_haz) begin
          pc_src   = PC_BRANCH;
          de_flush = 1'b1;
          ex_flush = 1'b1;
          ch_flush = 1'b1;
        end else if (load_use_haz) begin
          pc_src    = PC_HOLD;
          if_de_en  = 1'b0;
          ex_flush  = 1'b1;
          lu_bubble = 1'b1;
        end else if (state_q == DRAIN) begin
          pc_src   = PC_HOLD;
          de_flush = 1'b1;
        end
      end
      ENTER: begin
        intr_taken = 1'b1;
        pc_src     = PC_MTVEC;
        de_flush   = 1'b1;
        ex_flush   = 1'b1;
        state_d    = RUN;
      end
      default: state_d = RUN;
    endcase

    // A flush beats the enable of the same register and loads a bubble.
    de_valid_d  = de_flush ? 1'b0 : (if_de_en ? (state_q == RUN) : de_valid_q);
    ex_valid_d  = ex_flush ? 1'b0 : (de_ex_en ? de_valid_q : ex_valid_q);
    mem_valid_d = ex_mem_en ? ex_valid_q  : mem_valid_q;
    wb_valid_d  = mem_wb_en ? mem_valid_q : wb_valid_q;

    if (state_q == RUN && intr && intr_en && !mem_wait)
      state_d = DRAIN;
    // The instruction still in WB retires during the ENTER cycle itself.
    else if (state_q == DRAIN && !mem_wait && !ex_valid_d && !mem_valid_d)
      state_d = ENTER;
  end

  assign pc_wr = (pc_src != PC_HOLD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      de_valid_q  <= 1'b0;
      ex_valid_q  <= 1'b0;
      mem_valid_q <= 1'b0;
      wb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      de_valid_q  <= de_valid_d;
      ex_valid_q  <= ex_valid_d;
      mem_valid_q <= mem_valid_d;
      wb_valid_q  <= wb_valid_d;
    end
  end

  assign de_valid  = de_valid_q;
  assign ex_valid  = ex_valid_q;
  assign mem_valid = mem_valid_q;
  assign wb_valid  = wb_valid_q;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (!de_ex_en || lu_bubble),
    .clear (1'b0),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ch_flush),
    .clear (1'b0),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed scoreboard bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  // {rst, load_use, control, mem_wait, intr, intr_en}
  localparam logic [5:0] I_N   = 6'b000000;
  localparam logic [5:0] I_RST = 6'b100000;
  localparam logic [5:0] I_LU  = 6'b010000;
  localparam logic [5:0] I_CH  = 6'b001000;
  localparam logic [5:0] I_MW  = 6'b000100;
  localparam logic [5:0] I_IT  = 6'b000010;
  localparam logic [5:0] I_IE  = 6'b000001;

  typedef struct {
    int         id;
    logic [4:0] en;
    logic [1:0] fl;
    logic [3:0] v;
    logic [1:0] dt;
    int         sc;
    int         fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_use_haz = 1'b0, control_haz = 1'b0, mem_wait = 1'b0, intr = 1'b0, intr_en = 1'b0;
  logic pc_wr, if_de_en, de_ex_en, ex_mem_en, mem_wb_en, de_flush, ex_flush;
  logic de_valid, ex_valid, mem_valid, wb_valid, intr_taken, draining;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   vec_id  = 0;

  pipeline_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .load_use_haz (load_use_haz),
    .control_haz  (control_haz),
    .mem_wait     (mem_wait),
    .intr         (intr),
    .intr_en      (intr_en),
    .pc_wr        (pc_wr),
    .if_de_en     (if_de_en),
    .de_ex_en     (de_ex_en),
    .ex_mem_en    (ex_mem_en),
    .mem_wb_en    (mem_wb_en),
    .de_flush     (de_flush),
    .ex_flush     (ex_flush),
    .de_valid     (de_valid),
    .ex_valid     (ex_valid),
    .mem_valid    (mem_valid),
    .wb_valid     (wb_valid),
    .intr_taken   (intr_taken),
    .draining     (draining),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input int id, input string name, input int act, input int exp);
    n_total++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL vec%0d %s: got %0h expected %0h", id, name, act, exp);
  endtask

  // Drive one cycle of inputs after the edge and queue what the outputs must show.
  task automatic step(input logic [5:0] in, input logic [4:0] en, input logic [1:0] fl,
                      input logic [3:0] v, input logic [1:0] dt, input int sc, input int fc);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, load_use_haz, control_haz, mem_wait, intr, intr_en} = in;
    e.id = vec_id; e.en = en; e.fl = fl; e.v = v; e.dt = dt; e.sc = sc; e.fc = fc;
    exp_q.push_back(e);
    vec_id++;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk(e.id, "enables", int'({pc_wr, if_de_en, de_ex_en, ex_mem_en, mem_wb_en}), int'(e.en));
      chk(e.id, "flushes", int'({de_flush, ex_flush}), int'(e.fl));
      chk(e.id, "valids", int'({de_valid, ex_valid, mem_valid, wb_valid}), int'(e.v));
      chk(e.id, "drain_taken", int'({draining, intr_taken}), int'(e.dt));
      chk(e.id, "stall_cnt", int'(stall_cnt), e.sc);
      chk(e.id, "flush_cnt", int'(flush_cnt), e.fc);
    end
  end

  initial begin
    // reset, then fill the pipe
    step(I_RST, 5'b11111, 2'b00, 4'b0000, 2'b00, 0, 0);
    step(I_N,   5'b11111, 2'b00, 4'b0000, 2'b00, 0, 0);
    step(I_N,   5'b11111, 2'b00, 4'b1000, 2'b00, 0, 0);
    step(I_N,   5'b11111, 2'b00, 4'b1100, 2'b00, 0, 0);
    step(I_N,   5'b11111, 2'b00, 4'b1110, 2'b00, 0, 0);
    step(I_N,   5'b11111, 2'b00, 4'b1111, 2'b00, 0, 0);
    // load-use bubble
    step(I_LU,  5'b00111, 2'b01, 4'b1111, 2'b00, 0, 0);
    step(I_N,   5'b11111, 2'b00, 4'b1011, 2'b00, 1, 0);
    // control hazard masks a simultaneous load-use
    step(I_LU | I_CH, 5'b11111, 2'b11, 4'b1101, 2'b00, 1, 0);
    step(I_N,   5'b11111, 2'b00, 4'b0010, 2'b00, 1, 1);
    step(I_N,   5'b11111, 2'b00, 4'b1001, 2'b00, 1, 1);
    // three mem_wait cycles freeze the pipe
    step(I_MW,  5'b00000, 2'b00, 4'b1100, 2'b00, 1, 1);
    step(I_MW,  5'b00000, 2'b00, 4'b1100, 2'b00, 2, 1);
    step(I_MW,  5'b00000, 2'b00, 4'b1100, 2'b00, 3, 1);
    step(I_N,   5'b11111, 2'b00, 4'b1100, 2'b00, 4, 1);
    step(I_N,   5'b11111, 2'b00, 4'b1110, 2'b00, 4, 1);
    step(I_N,   5'b11111, 2'b00, 4'b1111, 2'b00, 4, 1);
    // masked request, then a taken one that drains a full pipe
    step(I_IT,  5'b11111, 2'b00, 4'b1111, 2'b00, 4, 1);
    step(I_IT | I_IE, 5'b11111, 2'b00, 4'b1111, 2'b00, 4, 1);
    step(I_IT | I_IE, 5'b01111, 2'b10, 4'b1111, 2'b10, 4, 1);
    step(I_N,   5'b01111, 2'b10, 4'b0111, 2'b10, 4, 1);
    step(I_N,   5'b01111, 2'b10, 4'b0011, 2'b10, 4, 1);
    step(I_N,   5'b11111, 2'b11, 4'b0001, 2'b01, 4, 1);
    step(I_N,   5'b11111, 2'b00, 4'b0000, 2'b00, 4, 1);
    step(I_N,   5'b11111, 2'b00, 4'b1000, 2'b00, 4, 1);
    step(I_N,   5'b11111, 2'b00, 4'b1100, 2'b00, 4, 1);
    // control hazard inside DRAIN
    step(I_IT | I_IE, 5'b11111, 2'b00, 4'b1110, 2'b00, 4, 1);
    step(I_CH,  5'b11111, 2'b11, 4'b1111, 2'b10, 4, 1);
    step(I_N,   5'b01111, 2'b10, 4'b0011, 2'b10, 4, 2);
    step(I_N,   5'b11111, 2'b11, 4'b0001, 2'b01, 4, 2);
    step(I_N,   5'b11111, 2'b00, 4'b0000, 2'b00, 4, 2);
    step(I_N,   5'b11111, 2'b00, 4'b1000, 2'b00, 4, 2);
    // reset in the middle of DRAIN
    step(I_IT | I_IE, 5'b11111, 2'b00, 4'b1100, 2'b00, 4, 2);
    step(I_N,   5'b01111, 2'b10, 4'b1110, 2'b10, 4, 2);
    step(I_RST, 5'b11111, 2'b00, 4'b0000, 2'b00, 0, 0);
    step(I_N,   5'b11111, 2'b00, 4'b0000, 2'b00, 0, 0);
    step(I_N,   5'b11111, 2'b00, 4'b1000, 2'b00, 0, 0);
    // 17 back-to-back control hazards saturate the 4-bit flush counter
    for (int k = 0; k < 17; k++) begin
      logic [3:0] v;
      v = (k == 0) ? 4'b1100 : (k == 1) ? 4'b0010 : (k == 2) ? 4'b0001 : 4'b0000;
      step(I_CH, 5'b11111, 2'b11, v, 2'b00, 0, (k > 15) ? 15 : k);
    end
    step(I_N,   5'b11111, 2'b00, 4'b0000, 2'b00, 0, 15);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++)
      @(posedge clk);
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain_queue: got %0d pending expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
